// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

    localparam int DIV_W_DEFAULT = 16;
    // Widest operand the negate helper covers; callers cast down to W.
    localparam int NEG_MAXW = 128;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    function automatic logic [NEG_MAXW-1:0] twos_neg(input logic [NEG_MAXW-1:0] v);
        return ~v + NEG_MAXW'(1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; the caller registers the result.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic [W-1:0] rem,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W+1:0] diff;

    // rem < divisor on entry, so the shifted value fits W+1 bits and the
    // kept difference always fits back into W bits.
    always_comb begin
        shifted  = {rem, dividend_bit};
        diff     = {1'b0, shifted} - {2'b00, divisor};
        q_bit    = ~diff[W+1];
        rem_next = q_bit ? W'(diff) : W'(shifted);
    end

endmodule

// File: rtl/seq_divider_param.sv
// Multi-cycle signed/unsigned restoring divider with start/busy/done handshake.
// W+1 cycles per divide (1 for divide-by-zero); starts are ignored while busy.
module seq_divider_param
    import div_pkg::*;
#(
    parameter int W  = DIV_W_DEFAULT,
    parameter int CW = $clog2(W+1)
) (
    input  logic         inp_clk,
    input  logic         inp_rst,
    input  logic         inp_start,
    input  logic         inp_signed,
    input  logic [W-1:0] inp_a,
    input  logic [W-1:0] inp_b,
    output logic         out_busy,
    output logic         out_done,
    output logic [W-1:0] out_quotient,
    output logic [W-1:0] out_remainder,
    output logic         out_div_by_zero
);

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  dvd;
    logic [W-1:0]  dvs;
    logic [W-1:0]  rem;
    logic          neg_q;
    logic          neg_r;
    logic          dz;

    logic [W-1:0]  step_rem;
    logic          step_q;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W-1:0]  q_fix;
    logic [W-1:0]  r_fix;

    div_step #(.W(W)) u_step (
        .rem          (rem),
        .dividend_bit (dvd[W-1]),
        .divisor      (dvs),
        .rem_next     (step_rem),
        .q_bit        (step_q)
    );

    // The most-negative value maps onto itself as an unsigned magnitude,
    // which is exactly what the unsigned core needs.
    always_comb begin
        a_mag = (inp_signed && inp_a[W-1]) ? W'(twos_neg(NEG_MAXW'(inp_a))) : inp_a;
        b_mag = (inp_signed && inp_b[W-1]) ? W'(twos_neg(NEG_MAXW'(inp_b))) : inp_b;
        q_fix = neg_q ? W'(twos_neg(NEG_MAXW'(dvd))) : dvd;
        r_fix = neg_r ? W'(twos_neg(NEG_MAXW'(rem))) : rem;
    end

    // dvd starts as the dividend magnitude and fills with quotient bits from
    // the bottom as the dividend bits leave the top.
    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            state           <= IDLE;
            cnt             <= '0;
            dvd             <= '0;
            dvs             <= '0;
            rem             <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            dz              <= 1'b0;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
            out_quotient    <= '0;
            out_remainder   <= '0;
            out_div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (inp_start) begin
                        out_done        <= 1'b0;
                        out_div_by_zero <= 1'b0;
                        out_busy        <= 1'b1;
                        neg_q           <= inp_signed & (inp_a[W-1] ^ inp_b[W-1]);
                        neg_r           <= inp_signed & inp_a[W-1];
                        dvs             <= b_mag;
                        if (inp_b == '0) begin
                            // Raw dividend parked in rem so FIX can return it untouched.
                            dz    <= 1'b1;
                            rem   <= inp_a;
                            dvd   <= '0;
                            cnt   <= '0;
                            state <= FIX;
                        end else begin
                            dz    <= 1'b0;
                            rem   <= '0;
                            dvd   <= a_mag;
                            cnt   <= CW'(W);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    dvd <= {dvd[W-2:0], step_q};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        out_quotient    <= '1;
                        out_remainder   <= rem;
                        out_div_by_zero <= 1'b1;
                    end else begin
                        out_quotient    <= q_fix;
                        out_remainder   <= r_fix;
                        out_div_by_zero <= 1'b0;
                    end
                    out_done <= 1'b1;
                    out_busy <= 1'b0;
                    state    <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Parametrised multi-cycle restoring divider: W-bit dividend / W-bit divisor -> W-bit quotient and W-bit remainder.
- Operates unsigned or two's-complement signed, selected per operation.
- Uses an explicit start/busy/done handshake and flags divide-by-zero.
- Sits beside the ALU as the long-latency divide unit. The pipeline stalls on out_busy and collects results on out_done.

Parameters:
- W, 16, operand/result width; legal range W >= 2.
- CW, $clog2(W+1), iteration counter width (derived; not overridden by users).

Ports:
- inp_clk  input  1  rising-edge clock.
- inp_rst  input  1  asynchronous, active-high reset.
- inp_start  input  1  request; sampled only when out_busy=0.
- inp_signed  input  1  1 = signed divide, 0 = unsigned; captured with inp_start.
- inp_a  input  W  dividend; captured with inp_start.
- inp_b  input  W  divisor; captured with inp_start.
- out_busy  output  1  high from the accept edge until the result is written.
- out_done  output  1  high while results are valid; held until the next accepted start.
- out_quotient  output  W  quotient.
- out_remainder  output  W  remainder.
- out_div_by_zero  output  1  set with out_done when inp_b was 0.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, counter=0, all outputs 0, internal operand registers 0. No partial result survives.
- FSM states:
  - IDLE: waiting.
  - CALC: W shift/subtract iterations.
  - FIX: sign correction and output write.
  - DONE: results held.
- Accept:
  - At a rising edge with inp_start=1 and state in {IDLE, DONE}, latch inp_a, inp_b and inp_signed.
  - Clear out_done and out_div_by_zero; set out_busy=1.
  - If inp_b=0, go to FIX; otherwise go to CALC with counter=W.
- Start while busy (CALC/FIX): ignored, with no effect on the operation in flight.
- Operand prep (at accept): when signed, take magnitudes |a| and |b|, and record neg_q = sign(a) XOR sign(b) and neg_r = sign(a). When unsigned, neg_q=neg_r=0.
- CALC (one iteration per edge):
  - Shift partial remainder left by 1, bringing in the next dividend bit (MSB first).
  - Trial subtract divisor magnitude using a W+1-bit subtract.
  - If non-negative: keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter; after the edge that brings the counter to 0, go to FIX.
- FIX (one edge):
  - Write out_quotient = neg_q ? -q : q and out_remainder = neg_r ? -r : r (W-bit two's complement, truncating).
  - Set out_done=1, out_busy=0; go to DONE.
- Latency: accept at edge t -> out_done high after edge t+W+1 (17 edges for W=16). Divide-by-zero completes after edge t+1.
- Divide-by-zero: out_quotient = all ones (both modes), out_remainder = dividend as presented, out_div_by_zero = 1.
- Signed overflow (most-negative / -1): out_quotient = most-negative, out_remainder = 0. This falls out of the truncating negate; no special path.
- Remainder sign: the remainder always takes the dividend's sign (truncating division); |remainder| < |divisor|.
- DONE: outputs are stable until the next accept. An accept in DONE drops out_done on that same edge, so there is no idle cycle between back-to-back ops.
- Inputs are ignored outside the accept edge, so changing inp_a/inp_b mid-operation has no effect.

Decomposition:
- Shared package div_pkg:
  - State enum {IDLE, CALC, FIX, DONE}.
  - Function for the W-bit two's-complement negate.
  - Default-width constant DIV_W_DEFAULT=16.
- One natural sub-module: div_step, a combinational single iteration (partial remainder, divisor -> next remainder, quotient bit), parametrised by W.
- The FSM, counter and sign handling stay in seq_divider_param.

Test Plan:
- W=16, unsigned, a=100, b=7, start one cycle -> out_busy high for 17 edges; out_done after edge t+17; q=14, r=2, dz=0.
- Signed, a=0xFF9C (-100), b=7 -> q=0xFFF2 (-14), r=0xFFFE (-2). Also a=100, b=0xFFF9 (-7) -> q=0xFFF2, r=2.
- Divide-by-zero, a=1234, b=0, unsigned -> after edge t+1: q=0xFFFF, r=1234, dz=1, done=1. Repeat signed with a=0xFFFF -> r=0xFFFF.
- Signed overflow, a=0x8000, b=0xFFFF -> q=0x8000, r=0. Unsigned 0xFFFF/1 -> q=0xFFFF, r=0.
- Handshake:
  - Start 1000/3, re-pulse start with 5/5 at cycle 4 -> ignored; result q=333, r=1.
  - Then start 5/5 while in DONE -> out_done falls on the accept edge; q=1, r=0 after 17 edges.
- Reset:
  - Assert inp_rst asynchronously mid-CALC (between clock edges) -> all outputs 0 immediately.
  - After release, FSM idles until a new start. Also rerun 100/7 with W=8 and W=32 -> same q/r; latency W+1.
